// File: rtl/ser_pkg.sv
// Shared constants, state type and length-code helper for the serializer/deserializer pair.
package ser_pkg;

    localparam int WIDTH    = 16;
    localparam int W_INDEX  = $clog2(WIDTH);
    localparam int MIN_BITS = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } deser_state_t;

    // Length code to bit count: 0 means a full word, codes below MIN_BITS carry nothing.
    function automatic logic [W_INDEX:0] mod_to_bits(input logic [W_INDEX-1:0] mod);
        logic [W_INDEX:0] bits;
        if (mod == {W_INDEX{1'b0}}) begin
            bits = (W_INDEX+1)'(WIDTH);
        end else if ({1'b0, mod} < (W_INDEX+1)'(MIN_BITS)) begin
            bits = {(W_INDEX+1){1'b0}};
        end else begin
            bits = {1'b0, mod};
        end
        return bits;
    endfunction

endpackage

// File: rtl/burst_deserializer.sv
// Rebuilds MSB-first serial bursts into left-aligned WIDTH-bit words with a length code.
// Optional runt_o pulse on discarded short bursts is enabled by DESERIALIZER_RUNT_FLAG_EN.
module burst_deserializer
    import ser_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               ser_data_i,
    input  logic               ser_data_val_i,
    output logic [WIDTH-1:0]   deser_data_o,
    output logic [W_INDEX-1:0] deser_data_mod_o,
    output logic               deser_data_val_o
`ifdef DESERIALIZER_RUNT_FLAG_EN
    ,
    output logic               runt_o
`endif
);

    deser_state_t       state_q, state_d;
    logic [W_INDEX-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [W_INDEX-1:0] mod_q, mod_d;
    logic               val_q, val_d;
    logic [WIDTH-1:0]   shift_in_s;
    logic [W_INDEX:0]   pad_s;

    assign shift_in_s = {shift_q[WIDTH-2:0], ser_data_i};
    // Zero-fill amount that moves a cnt-bit partial word up to the MSB end.
    assign pad_s      = (W_INDEX+1)'(WIDTH) - {1'b0, cnt_q};

    // Next-state, counter, shifter and output-load decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        mod_d   = mod_q;
        val_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ser_data_val_i) begin
                    shift_d = shift_in_s;
                    cnt_d   = W_INDEX'(1);
                    state_d = RECV;
                end else begin
                    cnt_d   = {W_INDEX{1'b0}};
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (ser_data_val_i) begin
                    shift_d = shift_in_s;
                    if (cnt_q == W_INDEX'(WIDTH-1)) begin
                        data_d  = shift_in_s;
                        mod_d   = {W_INDEX{1'b0}};
                        val_d   = 1'b1;
                        cnt_d   = {W_INDEX{1'b0}};
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + W_INDEX'(1);
                        state_d = RECV;
                    end
                end else begin
                    cnt_d   = {W_INDEX{1'b0}};
                    state_d = IDLE;
                    if (cnt_q >= W_INDEX'(MIN_BITS)) begin
                        data_d = shift_q << pad_s;
                        mod_d  = cnt_q;
                        val_d  = 1'b1;
                    end else begin
                        val_d  = 1'b0;
                    end
                end
            end
            default: begin
                cnt_d   = {W_INDEX{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // Receive state: FSM, bit counter and shift register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= {W_INDEX{1'b0}};
            shift_q <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Output registers; data and mod hold between valid pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= {WIDTH{1'b0}};
            mod_q  <= {W_INDEX{1'b0}};
            val_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            mod_q  <= mod_d;
            val_q  <= val_d;
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_mod_o = mod_q;
    assign deser_data_val_o = val_q;

`ifdef DESERIALIZER_RUNT_FLAG_EN
    logic runt_q, runt_d;

    // A burst ending with fewer than MIN_BITS bits is a runt.
    always_comb begin
        runt_d = 1'b0;
        if ((state_q == RECV) && !ser_data_val_i && (cnt_q < W_INDEX'(MIN_BITS))) begin
            runt_d = 1'b1;
        end else begin
            runt_d = 1'b0;
        end
    end

    // Runt flag register, one-cycle pulse aligned with a partial flush.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            runt_q <= 1'b0;
        end else begin
            runt_q <= runt_d;
        end
    end

    assign runt_o = runt_q;
`endif

endmodule

// File: tb/tb_burst_deserializer.sv
// Scoreboard bench for burst_deserializer: directed bursts plus a serializer-style loopback model.
module tb_burst_deserializer;
    import ser_pkg::*;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic               sd    = 1'b0;
    logic               sv    = 1'b0;
    logic [WIDTH-1:0]   dout;
    logic [W_INDEX-1:0] dmod;
    logic               dval;
`ifdef DESERIALIZER_RUNT_FLAG_EN
    logic               runt;
    int                 runt_seen = 0;
`endif

    typedef struct {
        logic [WIDTH-1:0]   data;
        logic [W_INDEX-1:0] mod;
        int                 cyc;
    } exp_t;

    exp_t               sb[$];
    exp_t               mon_e;
    int                 checks   = 0;
    int                 failures = 0;
    int                 cyc      = 0;
    logic [WIDTH-1:0]   last_data = '0;
    logic [W_INDEX-1:0] last_mod  = '0;

    burst_deserializer dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .ser_data_i       (sd),
        .ser_data_val_i   (sv),
        .deser_data_o     (dout),
        .deser_data_mod_o (dmod),
        .deser_data_val_o (dval)
`ifdef DESERIALIZER_RUNT_FLAG_EN
        ,
        .runt_o           (runt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Output registered on the edge after the current drive -> visible next cycle.
    task automatic expect_word(input logic [WIDTH-1:0] data, input logic [W_INDEX-1:0] mod);
        exp_t e;
        e.data = data;
        e.mod  = mod;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic d);
        @(posedge clk);
        #1;
        sv = v;
        sd = d;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    // Serializer model: sends the top N bits of data for the given length code.
    task automatic ser_send(input logic [WIDTH-1:0] data, input logic [W_INDEX-1:0] m);
        int               n;
        logic [WIDTH-1:0] mask;
        n    = int'(mod_to_bits(m));
        mask = ~({WIDTH{1'b1}} >> n);
        if (n != 0) begin
            for (int i = 0; i < n; i++) drive(1'b1, data[WIDTH-1-i]);
            if (n == WIDTH) expect_word(data, m);
            drive(1'b0, 1'b0);
            if (n != WIDTH) expect_word(data & mask, m);
        end
        idle(2);
    endtask

    // Monitor: pops the scoreboard on every valid pulse and checks hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dval) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    check("data", 32'(dout), 32'(mon_e.data));
                    check("mod", 32'(dmod), 32'(mon_e.mod));
                    check("latency_cycle", cyc, mon_e.cyc);
                end
                last_data = dout;
                last_mod  = dmod;
            end else begin
                check("hold_data", 32'(dout), 32'(last_data));
                check("hold_mod", 32'(dmod), 32'(last_mod));
            end
`ifdef DESERIALIZER_RUNT_FLAG_EN
            if (runt) runt_seen++;
`endif
        end else begin
            last_data = '0;
            last_mod  = '0;
        end
    end

    initial begin
        logic [WIDTH-1:0]   rd;
        logic [W_INDEX-1:0] rm;

        #12;
        check("reset_data", 32'(dout), 32'h0);
        check("reset_mod", 32'(dmod), 32'h0);
        check("reset_val", 32'(dval), 32'h0);
`ifdef DESERIALIZER_RUNT_FLAG_EN
        check("reset_runt", 32'(runt), 32'h0);
`endif
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(2);

        // Full word
        send_bits(32'hA5C3, 16);
        expect_word(16'hA5C3, 4'd0);
        idle(3);

        // Partial flush of 5 bits
        send_bits(32'b10110, 5);
        drive(1'b0, 1'b0);
        expect_word(16'hB000, 4'd5);
        idle(3);

        // Runt then minimum-length burst
        send_bits(32'b11, 2);
        idle(3);
        send_bits(32'b111, 3);
        drive(1'b0, 1'b0);
        expect_word(16'hE000, 4'd3);
        idle(3);

        // 20-bit contiguous stream: full word immediately followed by a partial
        send_bits(32'hFFFF, 16);
        expect_word(16'hFFFF, 4'd0);
        send_bits(32'b1010, 4);
        drive(1'b0, 1'b0);
        expect_word(16'hA000, 4'd4);
        idle(3);

        // Asynchronous reset mid-burst
        send_bits(32'b1010101, 7);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sv    = 1'b0;
        #1;
        check("midrst_data", 32'(dout), 32'h0);
        check("midrst_mod", 32'(dmod), 32'h0);
        check("midrst_val", 32'(dval), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(2);
        send_bits(32'h0001, 16);
        expect_word(16'h0001, 4'd0);
        idle(3);

        // Loopback through the serializer model
        ser_send(16'h1234, 4'd0);
        ser_send(16'hBEEF, 4'd7);
        ser_send(16'hFFFF, 4'd1);
        ser_send(16'hFFFF, 4'd2);
        for (int k = 0; k < 20; k++) begin
            rd = WIDTH'($urandom);
            rm = W_INDEX'($urandom_range(2, 15));
            if (rm == 4'd2) rm = 4'd0;
            ser_send(rd, rm);
        end

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        idle(3);
        check("scoreboard_drained", sb.size(), 0);
`ifdef DESERIALIZER_RUNT_FLAG_EN
        check("runt_count", runt_seen, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/burst_deserializer.md
Name: burst_deserializer

Overview:
Downstream companion of the serializer. It takes the 1-bit serial stream (ser_data/ser_data_val) and rebuilds parallel words of WIDTH bits, MSB first. Variable-length bursts are handled: a burst shorter than WIDTH is flushed as a left-aligned partial word with a length code that uses the serializer's data_mod encoding. A serializer-to-deserializer loopback is therefore lossless.

Parameters:
WIDTH, 16, parallel word width; maximum bits per emitted word.
W_INDEX, $clog2(WIDTH), width of the length code.
MIN_BITS, 3, shortest burst emitted as a word; shorter bursts are runts and are discarded.

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_n_i  input  1  reset, asynchronous, active-low
ser_data_i  input  1  serial data bit, MSB first
ser_data_val_i  input  1  bit qualifier; a contiguous high run is one burst
deser_data_o  output  WIDTH  rebuilt word; first received bit at [WIDTH-1]; unused LSBs zero
deser_data_mod_o  output  W_INDEX  bit count: 0 = WIDTH bits, else N (MIN_BITS..WIDTH-1)
deser_data_val_o  output  1  one-cycle pulse qualifying deser_data_o and deser_data_mod_o
runt_o  output  1  present only with DESERIALIZER_RUNT_FLAG_EN, one-cycle pulse

Behaviour:
- Reset: clock is one domain; reset is asynchronous and active-low.
  - While rst_n_i=0: shift register, bit counter and state are cleared.
  - While rst_n_i=0: deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, runt_o=0.
  - Reset mid-burst discards the partial word and emits no output.
  - The first valid bit after release starts a new word.
- States: IDLE (cnt=0) and RECV (0<cnt<WIDTH).
  - IDLE, val=1: shift the bit in, cnt=1, go to RECV.
  - RECV, val=1: shift the bit in, cnt++.
  - RECV, val=0: flush (see below), go to IDLE.
- Sampling: a bit is taken on every rising edge with ser_data_val_i=1; there is no backpressure.
- Full word: on the edge that samples bit WIDTH, output registers load the word and mod=0; cnt returns to 0.
  - deser_data_val_o is high for the following cycle only.
- Partial flush: on the first edge with ser_data_val_i=0 and MIN_BITS<=cnt<=WIDTH-1:
  - Load the word left-aligned, lower WIDTH-cnt bits zero, mod=cnt.
  - Valid pulses the next cycle.
  - Latency is 1 cycle after the val drop.
- Runt: 1<=cnt<MIN_BITS when val drops. The data is discarded and deser_data_val_o stays 0; the counter clears.
- Contiguous stream longer than WIDTH: bit WIDTH+1 on the next edge starts a new word with cnt=1.
  - No bit is lost.
  - Valid may then pulse on consecutive cycles (full word, then full or partial).
- Hold: deser_data_o and deser_data_mod_o keep their last emitted value between pulses; they only update when valid is asserted.
- Gaps: val=0 in IDLE does nothing.

Optional Feature:
DESERIALIZER_RUNT_FLAG_EN
- Defined:
  - runt_o exists.
  - runt_o pulses for one cycle, 1 cycle after val drops on a runt burst (same timing as a partial flush).
  - It is 0 otherwise and 0 in reset.
- Undefined: no port and no logic; runts are silently dropped.

Decomposition:
- Shared package ser_pkg holds:
  - WIDTH and W_INDEX constants, used by both serializer and deserializer.
  - MIN_BITS constant.
  - Length-code helper function: mod to bit count, 0->WIDTH, 1/2->0, else mod.
  - State enum typedef deser_state_t {IDLE, RECV}.
- No sub-module is needed. The shift register, counter and output register form one module.
- The loopback bench instantiates serializer and burst_deserializer side by side.

Test Plan:
- 16 contiguous bits of 16'hA5C3 MSB first -> next cycle data_o=16'hA5C3, mod=0, val=1 for exactly 1 cycle.
- Bits 1,0,1,1,0 then val low -> 1 cycle after the drop: data_o=16'hB000, mod=5, val pulse.
- Bits 1,1 then val low -> no val pulse; with the macro, runt_o=1 for 1 cycle. Next burst of 3 bits 1,1,1 -> data_o=16'hE000, mod=3.
- 20 contiguous bits, 16x'1' then 1,0,1,0, then drop -> 16'hFFFF mod 0, then 16'hA000 mod 4.
- rst_n_i low for 1 cycle after 7 bits, asynchronously mid-cycle -> outputs 0 at once, no val. Then 16'h0001 full -> data_o=16'h0001, mod=0.
- Loopback from the serializer with data_i=16'h1234, data_mod_i=0 and 16'hBEEF mod 7, plus 20 random pairs with mod in {0, 3..15} -> out top N bits equal data_i[15:16-N], lower bits 0, mod equal. Mod 1/2 -> no output.
